axi_rd_arbiter: RTL
===================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 3, number of read requester ports (range 2..8).
REQ-002 SHALL have parameter IDW, default 4, AXI ID width; NPORT SHALL be at most 2**IDW.
REQ-003 SHALL have parameter LENW, default 4, burst-length field width.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 req  input  NPORT  per-port read request.
REQ-007 req_addr  input  NPORT*32  per-port byte address, packed.
REQ-008 req_len  input  NPORT*LENW  per-port beats minus one.
REQ-009 req_ack  output  NPORT  one-hot request accepted pulse.
REQ-010 resp_valid  output  NPORT  one-hot data beat valid.
REQ-011 resp_last  output  1  final beat of burst.
REQ-012 resp_data  output  32  beat data, shared by all ports.
REQ-013 resp_err  output  1  rresp nonzero on current beat.
REQ-014 arid, araddr, arlen, arsize, arburst, arvalid  output  IDW/32/LENW/3/2/1  AXI AR channel.
REQ-015 arready  input  1  AXI AR accept.
REQ-016 rid, rdata, rresp, rlast, rvalid  input  IDW/32/2/1/1  AXI R channel.
REQ-017 rready  output  1  AXI R accept.

Function
REQ-018 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, one outstanding burst.
REQ-019 IDLE: if any req, SHALL grant one port, pulse its req_ack for one cycle, latch addr/len/index, go ADDR next cycle.
REQ-020 ADDR: arvalid=1, araddr/arlen from latch, arid=granted index, arsize=3'b010, arburst=2'b01; SHALL hold all AR fields stable until arvalid&&arready, then go DATA.
REQ-021 DATA: rready=1; each rvalid SHALL produce resp_valid[granted]=1 same cycle (combinational pass-through, zero latency) with resp_data=rdata, resp_last=rlast, resp_err=|rresp.
REQ-022 DATA: on rvalid&&rlast SHALL return to IDLE; new grant earliest the following cycle.
REQ-023 rvalid with rid != granted index SHALL still be consumed and forwarded; a sticky internal id_mismatch flag SHALL set (verification observable only).
REQ-024 Beat counter SHALL count accepted beats; rlast before counter reaches latched len, or counter wrapping past len without rlast, SHALL set resp_err on that beat; burst ends only on rlast.
REQ-025 req deasserted after req_ack SHALL NOT cancel the burst.
REQ-026 req_ack SHALL never assert outside IDLE; outputs in IDLE: arvalid=0, rready=0, resp_valid=0.

Reset
REQ-027 rst SHALL force IDLE, pointer to port 0, latches and counter to 0, id_mismatch cleared, all outputs 0 (arsize/arburst constant).
REQ-028 rst mid-burst SHALL abandon the burst; the bench/interconnect is reset together.

Configuration
REQ-029 With AXI_RD_RR_EN defined: round-robin; search starts at (last granted + 1) mod NPORT, wraps at NPORT-1 -> 0.
REQ-030 Without AXI_RD_RR_EN: fixed priority, lowest index wins; no pointer register.

Structure
REQ-031 FSM state enum, arsize/arburst constants and AXI response codes SHALL live in the shared AXI package.
REQ-032 Grant selection SHALL be one sub-module rr_arbiter (NPORT-wide, inputs req/pointer, output one-hot grant); fixed-priority mode uses it with pointer tied 0.

Verification
REQ-033 Single port 1, addr 0x1FC0_0000, len 3, arready after 2 cycles -> arid=1, arlen=3, four resp_valid[1] beats, resp_last on 4th, back to IDLE.
REQ-034 RR on, req=3'b111 held, bursts len 0 -> grant order 0,1,2,0; RR off -> 0,0,0.
REQ-035 arready held low 5 cycles -> araddr/arlen/arid unchanged across all 5 cycles.
REQ-036 Burst len 3 with rlast on beat 2, rresp=2'b10 on beat 1 -> resp_err on beats 1 and 2, return to IDLE after beat 2.
REQ-037 rst asserted during DATA beat 2 -> next cycle all outputs 0, IDLE; subsequent req on port 2 granted normally.
REQ-038 Port deasserts req the cycle after req_ack -> burst completes with all beats delivered to that port.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI definitions for the read arbiter.
// Contents: arbiter FSM state enum, fixed AR-channel encodings (arsize/arburst),
// AXI response codes and a helper that classifies an rresp value as an error.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  // Every beat is a full 32-bit word; bursts are incrementing.
  localparam logic [2:0] AxiSize4B    = 3'b010;
  localparam logic [1:0] AxiBurstIncr = 2'b01;

  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespExokay = 2'b01;
  localparam logic [1:0] AxiRespSlverr = 2'b10;
  localparam logic [1:0] AxiRespDecerr = 2'b11;

  // Anything other than OKAY is reported upstream as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    case (resp)
      AxiRespOkay:                                 err = 1'b0;
      AxiRespExokay, AxiRespSlverr, AxiRespDecerr: err = 1'b1;
      default:                                     err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant selector.
// Ports:
//   req   [NPORT-1:0] requests
//   ptr   [PTRW-1:0]  index that gets highest priority; search wraps NPORT-1 -> 0
//   grant [NPORT-1:0] one-hot grant (all zero when no request)
// Tying ptr to 0 yields plain fixed priority (lowest index wins).
module rr_arbiter #(
  parameter int unsigned NPORT = 3,
  parameter int unsigned PTRW  = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [PTRW-1:0]  ptr,
  output logic [NPORT-1:0] grant
);

  logic            found;
  logic [PTRW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      idx = PTRW'((32'(ptr) + i) % NPORT);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates NPORT read requesters onto one AXI read master, one burst at a time.
// Configuration macro: AXI_RD_RR_EN -- defined: round-robin grant starting after the
// last granted port; undefined: fixed priority, lowest index wins.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req/req_addr/req_len          per-port request, byte address, beats-1 (packed)
//   req_ack                       one-hot accept pulse (IDLE only)
//   resp_valid/last/data/err      zero-latency pass-through of R beats to granted port
//   arid..arvalid, arready        AXI AR channel (arid = granted port index)
//   rid..rvalid, rready           AXI R channel
// NPORT must not exceed 2**IDW so every port index fits in arid.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned NPORT = 3,
  parameter int unsigned IDW   = 4,
  parameter int unsigned LENW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT-1:0]      req,
  input  logic [NPORT*32-1:0]   req_addr,
  input  logic [NPORT*LENW-1:0] req_len,
  output logic [NPORT-1:0]      req_ack,
  output logic [NPORT-1:0]      resp_valid,
  output logic                  resp_last,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic [IDW-1:0]        arid,
  output logic [31:0]           araddr,
  output logic [LENW-1:0]       arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [IDW-1:0]        rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int unsigned PtrW = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [LENW-1:0]  beat_q, beat_d;
  logic [IDW-1:0]   idx_q, idx_d;
  logic [NPORT-1:0] gnt_q, gnt_d;
  logic             over_q, over_d;
  // Sticky rid/arid disagreement; kept only for observation in simulation.
  logic             id_mismatch_q, id_mismatch_d;

  logic [NPORT-1:0] grant;
  logic [PtrW-1:0]  ptr;
  logic [31:0]      sel_addr;
  logic [LENW-1:0]  sel_len;
  logic [IDW-1:0]   sel_idx;

  logic beat_fire, exp_last, proto_err;

`ifdef AXI_RD_RR_EN
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] sel_ptr;

  assign ptr = ptr_q;

  // Next search start is one past the port being granted now.
  always_comb begin
    sel_ptr = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (grant[i]) sel_ptr = (i == NPORT - 1) ? '0 : PtrW'(i + 1);
    end
  end
`else
  assign ptr = '0;
`endif

  rr_arbiter #(
    .NPORT(NPORT),
    .PTRW (PtrW)
  ) u_rr_arbiter (
    .req  (req),
    .ptr  (ptr),
    .grant(grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*32 +: 32];
        sel_len  = req_len[i*LENW +: LENW];
        sel_idx  = IDW'(i);
      end
    end
  end

  assign beat_fire = (state_q == StData) && rvalid;
  assign exp_last  = (beat_q == len_q);
  // Early rlast, missing rlast on the expected final beat, or any beat past it.
  assign proto_err = (rlast && !exp_last) || (!rlast && exp_last) || over_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    idx_d         = idx_q;
    gnt_d         = gnt_q;
    over_d        = over_q;
    id_mismatch_d = id_mismatch_q;
`ifdef AXI_RD_RR_EN
    ptr_d         = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StAddr;
          addr_d  = sel_addr;
          len_d   = sel_len;
          idx_d   = sel_idx;
          gnt_d   = grant;
          beat_d  = '0;
          over_d  = 1'b0;
`ifdef AXI_RD_RR_EN
          ptr_d   = sel_ptr;
`endif
        end
      end
      StAddr: begin
        if (arready) state_d = StData;
      end
      StData: begin
        if (rvalid) begin
          beat_d = beat_q + 1'b1;
          if (exp_last && !rlast) over_d = 1'b1;
          if (rid != idx_q) id_mismatch_d = 1'b1;
          // Only rlast ends the burst, whatever the counter says.
          if (rlast) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      idx_q         <= '0;
      gnt_q         <= '0;
      over_q        <= 1'b0;
      id_mismatch_q <= 1'b0;
`ifdef AXI_RD_RR_EN
      ptr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      idx_q         <= idx_d;
      gnt_q         <= gnt_d;
      over_q        <= over_d;
      id_mismatch_q <= id_mismatch_d;
`ifdef AXI_RD_RR_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  // Grant is suppressed while reset is held so no port sees a phantom accept.
  assign req_ack = ((state_q == StIdle) && !rst) ? grant : '0;

  assign arvalid = (state_q == StAddr);
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arid    = idx_q;
  assign arsize  = AxiSize4B;
  assign arburst = AxiBurstIncr;
  assign rready  = (state_q == StData);

  assign resp_valid = beat_fire ? gnt_q : '0;
  assign resp_data  = beat_fire ? rdata : '0;
  assign resp_last  = beat_fire && rlast;
  assign resp_err   = beat_fire && (resp_is_err(rresp) || proto_err);

endmodule
